// File: rtl/mod_mul_pipe.sv
// Three-stage Barrett modular multiplier: out = (in_a * in_b) mod P, one pair per cycle.
// S1 forms the full product, S2 the Barrett quotient estimate, S3 the remainder and final reduction.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

module mod_mul_pipe #(
    parameter int          W  = `DATAWIDTH,
    parameter int unsigned P  = 12289,
    parameter int unsigned K  = 28,
    parameter int unsigned MU = 21843
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    output logic [W-1:0] out
);

    localparam int XW = 2 * W;
    // Wide enough for x*MU with no truncation before the shift, whatever the modulus width.
    localparam int PW = XW + ((W > 16) ? W : 16);
    localparam logic [XW-1:0] P_X  = XW'(P);
    localparam logic [PW-1:0] MU_P = PW'(MU);

    logic          v1, v2;
    logic [XW-1:0] x1, x2, q2;

    logic [XW-1:0] x_next;
    logic [PW-1:0] prod, prod_shift;
    logic [XW-1:0] q_next;
    logic [XW-1:0] qp, r0, r1, r2;
    logic          unused_bits;

    always_comb begin
        x_next     = XW'(in_a) * XW'(in_b);
        prod       = MU_P * PW'(x1);
        prod_shift = prod >> K;
        q_next     = prod_shift[XW-1:0];
        qp         = q2 * P_X;
        // The Barrett estimate undershoots by at most two, so r0 lies in [0, 3P-1].
        r0         = x2 - qp;
        r1         = (r0 >= P_X) ? (r0 - P_X) : r0;
        r2         = (r1 >= P_X) ? (r1 - P_X) : r1;
    end

    assign unused_bits = ^{prod_shift[PW-1:XW], r2[XW-1:W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            x1        <= '0;
            x2        <= '0;
            q2        <= '0;
            out       <= '0;
        end else if (en) begin
            v1        <= in_valid;
            x1        <= x_next;
            v2        <= v1;
            x2        <= x1;
            q2        <= q_next;
            out_valid <= v2;
            out       <= r2[W-1:0];
        end
    end

endmodule

// File: tb/tb_mod_mul_pipe.sv
// Directed bench for mod_mul_pipe: default modulus 12289 and a 30-bit instance with P=343576577.
`timescale 1ns/1ps

module tb_mod_mul_pipe;

    localparam int          W1  = 16;
    localparam int unsigned P1  = 12289;
    localparam int unsigned K1  = 28;
    localparam int unsigned MU1 = 21843;

    localparam int              W2  = 30;
    localparam int unsigned     P2  = 343576577;
    localparam int unsigned     K2  = 58;
    localparam longint unsigned MU2L = (64'd1 << 58) / 64'd343576577;
    localparam int unsigned     MU2 = MU2L[31:0];

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid, in_valid2;
    logic [W1-1:0] in_a, in_b;
    logic [W2-1:0] in_a2, in_b2;
    logic          out_valid, out_valid2;
    logic [W1-1:0] out;
    logic [W2-1:0] out2;

    int vectors = 0;
    int errors  = 0;

    logic [W2-1:0] exp_q[$];

    always #5 clk = ~clk;

    mod_mul_pipe #(.W(W1), .P(P1), .K(K1), .MU(MU1)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out(out)
    );

    mod_mul_pipe #(.W(W2), .P(P2), .K(K2), .MU(MU2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid2),
        .in_a(in_a2), .in_b(in_b2), .out_valid(out_valid2), .out(out2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        in_valid = 1'b1; in_a = 16'd5; in_b = 16'd7;
        in_valid2 = 1'b1; in_a2 = 30'd5; in_b2 = 30'd7;
        tick(); tick(); tick();
        vectors++;
        if (out_valid !== 1'b0 || out !== 16'd0) begin
            errors++;
            $display("FAIL reset: out_valid=%b out=%0d, need 0/0", out_valid, out);
        end
        vectors++;
        if (out_valid2 !== 1'b0 || out2 !== 30'd0) begin
            errors++;
            $display("FAIL reset_alt: out_valid=%b out=%0d, need 0/0", out_valid2, out2);
        end
        rst = 1'b0; en = 1'b1;
        idle(3);
    endtask

    task automatic test_bounds();
        logic [W1-1:0] av[3];
        logic [W1-1:0] bv[3];
        logic [W1-1:0] ev[3];
        av = '{16'd12288, 16'd0, 16'd1};
        bv = '{16'd12288, 16'd12288, 16'd12288};
        ev = '{16'd1, 16'd0, 16'd12288};
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3);
            if (i < 3) begin in_a = av[i]; in_b = bv[i]; end
            tick();
            if (i >= 2) begin
                vectors++;
                if (out_valid !== 1'b1 || out !== ev[i-2]) begin
                    errors++;
                    $display("FAIL bounds[%0d]: out_valid=%b out=%0d, need 1/%0d", i-2, out_valid, out, ev[i-2]);
                end
            end
        end
        idle(3);
    endtask

    task automatic test_alt_bounds();
        logic [W2-1:0] av[3];
        logic [W2-1:0] bv[3];
        logic [W2-1:0] ev[3];
        av = '{30'd343576576, 30'd0, 30'd1};
        bv = '{30'd343576576, 30'd343576576, 30'd343576576};
        ev = '{30'd1, 30'd0, 30'd343576576};
        for (int i = 0; i < 5; i++) begin
            in_valid2 = (i < 3);
            if (i < 3) begin in_a2 = av[i]; in_b2 = bv[i]; end
            tick();
            if (i >= 2) begin
                vectors++;
                if (out_valid2 !== 1'b1 || out2 !== ev[i-2]) begin
                    errors++;
                    $display("FAIL alt_bounds[%0d]: out_valid=%b out=%0d, need 1/%0d", i-2, out_valid2, out2, ev[i-2]);
                end
            end
        end
        idle(3);
    endtask

    task automatic test_stall();
        logic [W1-1:0] ev[3];
        ev = '{16'd12, 16'd30, 16'd56};
        in_valid = 1'b1;
        in_a = 16'd3; in_b = 16'd4; tick();
        in_a = 16'd5; in_b = 16'd6; tick();
        in_a = 16'd7; in_b = 16'd8; tick();
        // Junk valid inputs during the stall must be ignored.
        en = 1'b0; in_a = 16'd9; in_b = 16'd9;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out !== ev[0]) begin
                errors++;
                $display("FAIL stall_hold[%0d]: out_valid=%b out=%0d, need 1/12", i, out_valid, out);
            end
        end
        en = 1'b1; in_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out !== ev[i]) begin
                errors++;
                $display("FAIL stall_drain[%0d]: out_valid=%b out=%0d, need 1/%0d", i, out_valid, out, ev[i]);
            end
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_nodup: out_valid=%b, need 0", out_valid);
        end
        idle(2);
    endtask

    task automatic test_reset_midflight();
        in_valid = 1'b1;
        in_a = 16'd2; in_b = 16'd3; tick();
        in_a = 16'd4; in_b = 16'd5; tick();
        in_valid = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out !== 16'd0) begin
            errors++;
            $display("FAIL midflight_reset: out_valid=%b out=%0d, need 0/0", out_valid, out);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midflight_stale[%0d]: out_valid=%b out=%0d, need 0", i, out_valid, out);
            end
        end
    endtask

    task automatic test_bubbles();
        logic          vpat[20];
        logic [W1-1:0] ev[20];
        idle(3);
        for (int i = 0; i < 20; i++) begin
            vpat[i] = ((i % 2) == 0);
            ev[i]   = W1'(((i + 100) * (i + 7)) % P1);
        end
        for (int i = 0; i < 23; i++) begin
            in_valid = (i < 20) ? vpat[i] : 1'b0;
            in_a = W1'(i + 100); in_b = W1'(i + 7);
            tick();
            if (i >= 2) begin
                vectors++;
                if (out_valid !== vpat[i-2] || (vpat[i-2] && out !== ev[i-2])) begin
                    errors++;
                    $display("FAIL bubble[%0d]: out_valid=%b out=%0d, need %b/%0d", i-2, out_valid, out, vpat[i-2], ev[i-2]);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back(input bit alt, input int n);
        longint unsigned a, b, p;
        int bad = 0;
        p = alt ? 64'(P2) : 64'(P1);
        exp_q.delete();
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                a = 64'($urandom_range(int'(p - 1), 0));
                b = 64'($urandom_range(int'(p - 1), 0));
                exp_q.push_back(W2'((a * b) % p));
                if (alt) begin in_valid2 = 1'b1; in_a2 = W2'(a); in_b2 = W2'(b); end
                else     begin in_valid  = 1'b1; in_a  = W1'(a); in_b  = W1'(b); end
            end else begin
                in_valid = 1'b0; in_valid2 = 1'b0;
            end
            tick();
            if (i >= 2) begin
                logic [W2-1:0] e;
                logic [W2-1:0] got;
                logic          gv;
                e   = exp_q.pop_front();
                got = alt ? out2 : W2'(out);
                gv  = alt ? out_valid2 : out_valid;
                vectors++;
                if (gv !== 1'b1 || got !== e) begin
                    errors++;
                    if (bad < 10)
                        $display("FAIL stream%s[%0d]: out_valid=%b out=%0d, need 1/%0d", alt ? "_alt" : "", i-2, gv, got, e);
                    bad++;
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_leftover: %0d results never seen, need 0", exp_q.size());
        end
        idle(3);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0;
        test_reset();
        test_bounds();
        test_stall();
        test_reset_midflight();
        test_bubbles();
        test_back_to_back(1'b0, 1000);
        test_alt_bounds();
        test_back_to_back(1'b1, 1000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
